// File: rtl/accum_track_pkg.sv
// ---------------------------------------------------------------------------
// accum_track_pkg
// Shared definitions for the accumulator wrap tracker slice.
//   TRACK_EXT_BITS : width of the extended value carried in a FIFO entry.
//                    The tracker's EXT_BITS parameter must equal this value,
//                    because the packed entry type is fixed at package level.
//   ST_*           : tracker FSM state encodings.
//   fifo_entry_t   : one buffered result {wrap flag, extended value}.
// ---------------------------------------------------------------------------
package accum_track_pkg;

  localparam int TRACK_EXT_BITS = 16;

  // Tracker FSM states
  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  typedef struct packed {
    logic                      wrap;
    logic [TRACK_EXT_BITS-1:0] value;
  } fifo_entry_t;

endpackage

// File: rtl/track_fifo.sv
// ---------------------------------------------------------------------------
// track_fifo
// DEPTH-entry synchronous FIFO of fifo_entry_t with a combinational head.
// Ports:
//   clock     in   rising-edge clock
//   rst_n     in   synchronous active-low reset (empties the FIFO)
//   push      in   request to write push_data
//   pop       in   request to drop the head entry (ignored when empty)
//   push_data in   entry to write
//   full      out  all DEPTH entries occupied
//   empty     out  no entries held
//   head      out  oldest entry, all zeros when empty
// A push while full is accepted only if a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module track_fifo
  import accum_track_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t push_data,
  output logic        full,
  output logic        empty,
  output fifo_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  fifo_entry_t mem [DEPTH];

  logic do_pop;
  logic do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/accum_wrap_tracker.sv
// ---------------------------------------------------------------------------
// accum_wrap_tracker
// Follows a wrapping IN_BITS accumulator that advances by STEP per valid
// sample, checks the sequence, extends the value to EXT_BITS by counting
// wrap-arounds and buffers {wrap, value} results in a small FIFO.
// Ports:
//   clock      in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_value holds a new sample
//   in_value   in   accumulator sample (IN_BITS)
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer takes the head when out_valid is high
//   out_value  out  head extended value (EXT_BITS), 0 when empty
//   out_wrap   out  head entry came from an input wrap, 0 when empty
//   locked     out  tracker is in LOCKED
//   seq_err    out  one-cycle pulse after a sequence mismatch
//   overflow   out  sticky: a push was dropped on a full FIFO
// Optional (macro ACCUM_WRAP_TRACKER_STATS_EN):
//   wrap_count out  16-bit count of accepted wrapping samples (modulo)
//   drop_count out  8-bit saturating count of dropped pushes
// EXT_BITS must equal accum_track_pkg::TRACK_EXT_BITS.
// ---------------------------------------------------------------------------
module accum_wrap_tracker
  import accum_track_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int STEP     = 6,
  parameter int EXT_BITS = TRACK_EXT_BITS,
  parameter int DEPTH    = 4
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXT_BITS-1:0] out_value,
  output logic                out_wrap,
  output logic                locked,
  output logic                seq_err,
  output logic                overflow
`ifdef ACCUM_WRAP_TRACKER_STATS_EN
  ,
  output logic [15:0]         wrap_count,
  output logic [7:0]          drop_count
`endif
);

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [IN_BITS-1:0]  prev;
  logic [IN_BITS-1:0]  prev_next;
  logic [EXT_BITS-1:0] ext;
  logic [EXT_BITS-1:0] ext_next;
  logic [IN_BITS-1:0]  expected;
  logic                match;
  logic                push;
  logic                push_wrap;
  logic                err_next;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  fifo_entry_t         push_data;
  fifo_entry_t         head;

  assign expected = prev + IN_BITS'(STEP);
  assign match    = (in_value == expected);

  always_comb begin
    state_next = state;
    prev_next  = prev;
    ext_next   = ext;
    push       = 1'b0;
    push_wrap  = 1'b0;
    err_next   = 1'b0;
    if (in_valid) begin
      case (state)
        ST_UNLOCKED: begin
          prev_next  = in_value;
          ext_next   = EXT_BITS'(in_value);
          push       = 1'b1;
          state_next = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (match) begin
            ext_next  = ext + EXT_BITS'(STEP);
            // A smaller sample than the previous one means the input wrapped
            push_wrap = (in_value < prev);
            prev_next = in_value;
            push      = 1'b1;
          end else begin
            err_next   = 1'b1;
            state_next = ST_FAULT;
          end
        end
        ST_FAULT: begin
          // Keep the accumulated wrap history, resync the low bits
          ext_next   = {ext[EXT_BITS-1:IN_BITS], in_value};
          prev_next  = in_value;
          push       = 1'b1;
          state_next = ST_LOCKED;
        end
        default: begin
          state_next = ST_UNLOCKED;
        end
      endcase
    end
  end

  always_comb begin
    push_data       = '0;
    push_data.wrap  = push_wrap;
    push_data.value = ext_next;
  end

  assign pop  = out_valid && out_ready;
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state    <= ST_UNLOCKED;
      prev     <= '0;
      ext      <= '0;
      seq_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      prev     <= prev_next;
      ext      <= ext_next;
      seq_err  <= err_next;
      overflow <= overflow | drop;
    end
  end

`ifdef ACCUM_WRAP_TRACKER_STATS_EN
  // Wrap flag is only ever set by an accepted LOCKED sample
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wrap_count <= '0;
      drop_count <= '0;
    end else begin
      if (push && push_wrap)
        wrap_count <= wrap_count + 16'd1;
      if (drop && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end
`endif

  track_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .push_data(push_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign out_valid = !fifo_empty;
  assign out_value = head.value;
  assign out_wrap  = head.wrap;
  assign locked    = (state == ST_LOCKED);

endmodule

// File: tb/tb_accum_wrap_tracker.sv
// ---------------------------------------------------------------------------
// tb_accum_wrap_tracker
// Directed self-checking bench for accum_wrap_tracker at default parameters
// (IN_BITS=8, STEP=6, EXT_BITS=16, DEPTH=4). Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_accum_wrap_tracker;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_value = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_value;
  logic        out_wrap;
  logic        locked;
  logic        seq_err;
  logic        overflow;
`ifdef ACCUM_WRAP_TRACKER_STATS_EN
  logic [15:0] wrap_count;
  logic [7:0]  drop_count;
`endif

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  val;
    logic        rdy;
    logic        e_ov;
    logic [15:0] e_val;
    logic        e_wrap;
    logic        e_lock;
    logic        e_err;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  accum_wrap_tracker dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_value (in_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_wrap (out_wrap),
    .locked   (locked),
    .seq_err  (seq_err),
    .overflow (overflow)
`ifdef ACCUM_WRAP_TRACKER_STATS_EN
    ,
    .wrap_count(wrap_count),
    .drop_count(drop_count)
`endif
  );

  function automatic vec_t mk(logic rst, logic vld, logic [7:0] val, logic rdy,
                              logic e_ov, logic [15:0] e_val, logic e_wrap,
                              logic e_lock, logic e_err, logic e_ovf);
    vec_t v;
    v.rst = rst; v.vld = vld; v.val = val; v.rdy = rdy;
    v.e_ov = e_ov; v.e_val = e_val; v.e_wrap = e_wrap;
    v.e_lock = e_lock; v.e_err = e_err; v.e_ovf = e_ovf;
    return v;
  endfunction

  // One clock cycle: drive on the falling edge, settle after the rising edge
  task automatic apply_stimulus(input logic rst, input logic vld,
                                input logic [7:0] val, input logic rdy);
    @(negedge clock);
    rst_n     = !rst;
    in_valid  = vld;
    in_value  = val;
    out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic e_ov, input logic [15:0] e_val,
                           input logic e_wrap, input logic e_lock, input logic e_err,
                           input logic e_ovf);
    check_output({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    check_output({tag, ".out_value"}, 32'(out_value), 32'(e_val));
    check_output({tag, ".out_wrap"},  32'(out_wrap),  32'(e_wrap));
    check_output({tag, ".locked"},    32'(locked),    32'(e_lock));
    check_output({tag, ".seq_err"},   32'(seq_err),   32'(e_err));
    check_output({tag, ".overflow"},  32'(overflow),  32'(e_ovf));
  endtask

  // Check the head before taking it, then pop it
  task automatic drain_expect(input string tag, input logic [15:0] exp);
    check_output({tag, ".drain_valid"}, 32'(out_valid), 32'd1);
    check_output({tag, ".drain_value"}, 32'(out_value), 32'(exp));
    apply_stimulus(1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  initial begin
    // Streaming, wrap, resync and fault vectors with out_ready held high
    //                rst vld val   rdy ov  value  wrap lock err ovf
    vecs.push_back(mk(1, 0, 8'd0,   1,  0, 16'd0,   0,  0,  0,  0));
    vecs.push_back(mk(0, 1, 8'd0,   1,  1, 16'd0,   0,  1,  0,  0));
    vecs.push_back(mk(0, 1, 8'd6,   1,  1, 16'd6,   0,  1,  0,  0));
    vecs.push_back(mk(0, 1, 8'd12,  1,  1, 16'd12,  0,  1,  0,  0));
    vecs.push_back(mk(1, 0, 8'd0,   1,  0, 16'd0,   0,  0,  0,  0));
    vecs.push_back(mk(0, 1, 8'd246, 1,  1, 16'd246, 0,  1,  0,  0));
    vecs.push_back(mk(0, 1, 8'd252, 1,  1, 16'd252, 0,  1,  0,  0));
    vecs.push_back(mk(0, 1, 8'd2,   1,  1, 16'd258, 1,  1,  0,  0));
    vecs.push_back(mk(0, 1, 8'd9,   1,  0, 16'd0,   0,  0,  1,  0));
    vecs.push_back(mk(0, 1, 8'd50,  1,  1, 16'd306, 0,  1,  0,  0));
    vecs.push_back(mk(1, 0, 8'd0,   1,  0, 16'd0,   0,  0,  0,  0));
    vecs.push_back(mk(0, 1, 8'd0,   1,  1, 16'd0,   0,  1,  0,  0));
    vecs.push_back(mk(0, 1, 8'd6,   1,  1, 16'd6,   0,  1,  0,  0));
    vecs.push_back(mk(0, 1, 8'd13,  1,  0, 16'd0,   0,  0,  1,  0));
    vecs.push_back(mk(0, 1, 8'd19,  1,  1, 16'd19,  0,  1,  0,  0));
    vecs.push_back(mk(0, 0, 8'd0,   1,  0, 16'd0,   0,  1,  0,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].vld, vecs[i].val, vecs[i].rdy);
      check_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_val,
                vecs[i].e_wrap, vecs[i].e_lock, vecs[i].e_err, vecs[i].e_ovf);
    end

    // Overflow: fill with consumer stalled, fifth sample is dropped
    apply_stimulus(1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 1'b1, 8'(6 * i), 1'b0);
    check_all("ovf.full", 1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'd24, 1'b0);
    check_all("ovf.drop", 1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef ACCUM_WRAP_TRACKER_STATS_EN
    check_output("ovf.drop_count", 32'(drop_count), 32'd1);
`endif
    for (int i = 0; i < 4; i++)
      drain_expect($sformatf("ovf.d%0d", i), 16'(6 * i));
    check_all("ovf.empty", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Full FIFO with simultaneous pop and push: nothing is dropped
    apply_stimulus(1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 1'b1, 8'(6 * i), 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'd24, 1'b1);
    check_all("pp.same", 1'b1, 16'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      drain_expect($sformatf("pp.d%0d", i), 16'(6 * (i + 1)));
    check_all("pp.empty", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream discards buffered entries and the lock
    apply_stimulus(1'b1, 1'b0, 8'd0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'd0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'd6, 1'b0);
    check_all("rst.buf", 1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'd0, 1'b0);
    check_all("rst.mid", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'd100, 1'b1);
    check_all("rst.relock", 1'b1, 16'd100, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
